logic_seq32: RTL and testbench

- Multi-cycle 32-bit logic unit for the MiniMIPS datapath: the sequential, handshaked counterpart of the combinational and32 family.
- Accepts an operand pair plus opcode on a valid/ready input interface and computes AND/OR/XOR/NOR one SLICE-bit chunk per cycle.
- Presents the registered result on a valid/ready output interface.
- Sits between the issue stage and writeback for multi-cycle ALU operations.

---
 rtl/logic_seq32.sv | 106 ++++++++++
 tb/tb_logic_seq32.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/logic_seq32.sv
// Multi-cycle AND/OR/XOR/NOR unit: SLICE bits per cycle, valid/ready on both sides.
// Result and zero flag are registered and held until the consumer takes them.
module logic_seq32 #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [1:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] R,
   output logic             zero
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   typedef enum logic [1:0] {OP_AND = 2'b00, OP_OR = 2'b01, OP_XOR = 2'b10, OP_NOR = 2'b11} op_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_next;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   op_t              opc;
   logic [SLICE-1:0] sa;
   logic [SLICE-1:0] sb;
   logic [SLICE-1:0] sr;

   // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
   always_comb begin
      sa       = opa[int'(cnt)*SLICE +: SLICE];
      sb       = opb[int'(cnt)*SLICE +: SLICE];
      sr       = '0;
      acc_next = acc;
      case (opc)
         OP_AND:  sr = sa & sb;
         OP_OR:   sr = sa | sb;
         OP_XOR:  sr = sa ^ sb;
         OP_NOR:  sr = ~(sa | sb);
         default: sr = '0;
      endcase
      acc_next[int'(cnt)*SLICE +: SLICE] = sr;
   end

   assign in_ready = (state == IDLE) && !reset;

   // NOTE: operand registers are pure data, only read after an accept loads them, so they carry no reset.
   always_ff @(posedge clk) begin
      if (in_valid && in_ready) begin
         opa <= A;
         opb <= B;
         opc <= op_t'(op);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         acc       <= '0;
         R         <= '0;
         zero      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  cnt   <= '0;
                  acc   <= '0;
                  state <= BUSY;
               end
            end
            BUSY: begin
               acc <= acc_next;
               if (cnt == LAST) begin
                  R         <= acc_next;
                  zero      <= (acc_next == '0);
                  out_valid <= 1'b1;
                  cnt       <= '0;
                  state     <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_logic_seq32.sv
// Directed bench for logic_seq32: stimulus pushes expected results into a scoreboard
// queue, an independent monitor pops and compares on every output handshake.
module tb_logic_seq32;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] A;
   logic [31:0] B;
   logic [1:0]  op;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] R;
   logic        zero;

   typedef struct {
      logic [31:0] r;
      logic        z;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   logic_seq32 #(.WIDTH(32), .SLICE(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .R         (R),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: outputs are sampled on the falling edge, half a cycle from the active edge.
   always @(negedge clk) begin
      if (!reset && out_valid) begin
         if (sb_q.size() == 0) begin
            check("unexpected out_valid", {31'd0, out_valid}, 32'd0);
         end else if (out_ready) begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb R", R, e.r);
            check("sb zero", {31'd0, zero}, {31'd0, e.z});
         end
      end
   end

   // Called #1 after a rising edge; returns #1 after the accepting edge.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o,
                        input logic [31:0] er, input logic ez, input bit push, input string tag);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) check({tag, " in_ready timeout"}, {31'd0, in_ready}, 32'd1);
      A = a; B = b; op = o; in_valid = 1'b1;
      if (push) sb_q.push_back('{er, ez});
      @(posedge clk); #1;
      in_valid = 1'b0;
      check({tag, " in_ready drop"}, {31'd0, in_ready}, 32'd0);
   endtask

   task automatic wait_result(input string tag);
      int lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, " latency"}, lat, 32'd4);
   endtask

   task automatic finish_hs(input string tag);
      @(posedge clk); #1;
      check({tag, " out_valid cleared"}, {31'd0, out_valid}, 32'd0);
      check({tag, " in_ready back"}, {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      A = '0; B = '0; op = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      check("in_ready during reset", {31'd0, in_ready}, 32'd0);
      reset = 1'b0;
      #1;
      check("reset out_valid", {31'd0, out_valid}, 32'd0);
      check("reset R", R, 32'd0);
      check("reset zero", {31'd0, zero}, 32'd0);
      check("reset in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;

      issue(32'hFFFF_FFFF, 32'h40A0_0400, 2'b00, 32'h40A0_0400, 1'b0, 1, "and0");
      wait_result("and0");
      finish_hs("and0");

      issue(32'h2222_0225, 32'hC242_0423, 2'b00, 32'h0202_0021, 1'b0, 1, "and1");
      wait_result("and1");
      finish_hs("and1");
      issue(32'h2222_0225, 32'hC242_0423, 2'b01, 32'hE262_0627, 1'b0, 1, "or1");
      wait_result("or1");
      finish_hs("or1");
      issue(32'h2222_0225, 32'hC242_0423, 2'b10, 32'hE060_0606, 1'b0, 1, "xor1");
      wait_result("xor1");
      finish_hs("xor1");

      issue(32'hFFFF_FFFF, 32'h1234_5678, 2'b11, 32'h0000_0000, 1'b1, 1, "nor");
      wait_result("nor");
      finish_hs("nor");

      // Operand change during BUSY: a held request is taken only once IDLE again.
      issue(32'hFFFF_FFFF, 32'h0000_FFFF, 2'b00, 32'h0000_FFFF, 1'b0, 1, "chg");
      A = '0; B = '0; op = 2'b01; in_valid = 1'b1;
      sb_q.push_back('{32'h0000_0000, 1'b1});
      wait_result("chg");
      @(posedge clk); #1;
      check("chg idle in_ready", {31'd0, in_ready}, 32'd1);
      check("chg idle out_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      check("chg second accept", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b0;
      wait_result("chg2");
      finish_hs("chg2");

      // Backpressure: result held stable with out_ready low.
      out_ready = 1'b0;
      issue(32'h1234_5678, 32'h0000_0000, 2'b01, 32'h1234_5678, 1'b0, 1, "bp");
      wait_result("bp");
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("bp out_valid", {31'd0, out_valid}, 32'd1);
         check("bp R", R, 32'h1234_5678);
         check("bp zero", {31'd0, zero}, 32'd0);
         check("bp in_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      finish_hs("bp");
      check("bp R kept", R, 32'h1234_5678);

      // Reset in the second BUSY cycle aborts with no result.
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 32'h0, 1'b0, 0, "rst");
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check("rst out_valid", {31'd0, out_valid}, 32'd0);
      check("rst R", R, 32'd0);
      check("rst zero", {31'd0, zero}, 32'd0);
      check("rst in_ready high", {31'd0, in_ready}, 32'd0);
      reset = 1'b0;
      #1;
      check("rst in_ready after", {31'd0, in_ready}, 32'd1);
      repeat (8) @(posedge clk);
      #1;
      check("rst no stale", {31'd0, out_valid}, 32'd0);

      issue(32'hFFFF_0000, 32'h0F0F_0F0F, 2'b10, 32'hF0F0_0F0F, 1'b0, 1, "post");
      wait_result("post");
      finish_hs("post");

      check("scoreboard drained", sb_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
